commit_trace_unit: RTL and testbench

Synthesizable retirement monitor on the processor's writeback/commit boundary. Each cycle it turns the committed-instruction signals (register write, load, store, halt, cache activity) into one packed trace record. Records are buffered in a small FIFO, drained over a valid/ready port, and the unit keeps cycle, instruction and drop counters. It replaces simulation-only tracing so retire traces and statistics are available on silicon and FPGA builds.

---
 rtl/commit_trace_unit.sv | 167 ++++++++++++++++
 tb/tb_commit_trace_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_unit.sv
// commit_trace_unit: packs each committed instruction into a 38-bit trace record,
// buffers records in a DEPTH-entry FIFO drained over valid/ready, and keeps cycle,
// instruction and drop counters. Define TRACE_CACHE_STATS_EN to add cache event counters.
module commit_trace_unit #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c_reg_wr_i,
  input  logic [2:0]       c_reg_sel_i,
  input  logic [15:0]      c_reg_data_i,
  input  logic             c_mem_rd_i,
  input  logic             c_mem_wr_i,
  input  logic [15:0]      c_mem_addr_i,
  input  logic [15:0]      c_mem_wdata_i,
  input  logic [15:0]      c_mem_rdata_i,
  input  logic             c_halt_i,
  input  logic             c_icache_req_i,
  input  logic             c_icache_hit_i,
  input  logic             c_dcache_req_i,
  input  logic             c_dcache_hit_i,
  output logic             trc_valid_o,
  input  logic             trc_ready_i,
  output logic [37:0]      trc_data_o,
  output logic             halted_o,
  output logic             overflow_o,
  output logic [15:0]      drop_count_o,
`ifdef TRACE_CACHE_STATS_EN
  output logic [CNT_W-1:0] icache_req_count_o,
  output logic [CNT_W-1:0] icache_hit_count_o,
  output logic [CNT_W-1:0] dcache_req_count_o,
  output logic [CNT_W-1:0] dcache_hit_count_o,
`endif
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] inst_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [37:0]      mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             halted_q, halted_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_q, drop_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d;

  logic        active, full, empty, pop, push, drop;
  logic [1:0]  rec_type;
  logic [2:0]  rec_reg;
  logic [15:0] rec_addr, rec_data;
  logic [37:0] rec;

  assign active = (c_reg_wr_i | c_mem_rd_i | c_mem_wr_i | c_halt_i) & ~halted_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop    = ~empty & trc_ready_i;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push   = active & (~full | pop);
  assign drop   = active & full & ~pop;

  // Record field selection; store beats load beats register write beats bare halt.
  always_comb begin
    rec_type = 2'b11;
    rec_reg  = 3'd0;
    rec_addr = 16'h0000;
    rec_data = 16'h0000;
    if (c_mem_wr_i) begin
      rec_type = 2'b10;
      rec_addr = c_mem_addr_i;
      rec_data = c_mem_wdata_i;
    end else if (c_mem_rd_i) begin
      rec_type = 2'b01;
      rec_addr = c_mem_addr_i;
      rec_data = c_mem_rdata_i;
      rec_reg  = c_reg_wr_i ? c_reg_sel_i : 3'd0;
    end else if (c_reg_wr_i) begin
      rec_type = 2'b00;
      rec_reg  = c_reg_sel_i;
      rec_data = c_reg_data_i;
    end
  end

  assign rec = {c_halt_i, rec_type, rec_reg, rec_addr, rec_data};

  // Next-state for pointers, sticky flags and counters.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    halted_d   = halted_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    cycle_d    = cycle_q;
    inst_d     = inst_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
    if (!halted_q) cycle_d = cycle_q + CNT_W'(1);
    if (active && (c_halt_i || c_reg_wr_i || c_mem_wr_i)) inst_d = inst_q + CNT_W'(1);
    if (active && c_halt_i) halted_d = 1'b1;
  end

  // State registers; reset discards any buffered records.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= 16'h0000;
      cycle_q    <= '0;
      inst_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      halted_q   <= halted_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      cycle_q    <= cycle_d;
      inst_q     <= inst_d;
    end
  end

  // FIFO storage; contents are only observable through valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= rec;
  end

  assign trc_valid_o   = ~empty;
  assign trc_data_o    = empty ? 38'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign halted_o      = halted_q;
  assign overflow_o    = overflow_q;
  assign drop_count_o  = drop_q;
  assign cycle_count_o = cycle_q;
  assign inst_count_o  = inst_q;

`ifdef TRACE_CACHE_STATS_EN
  logic [CNT_W-1:0] ireq_q, ihit_q, dreq_q, dhit_q;

  // Cache event counters, frozen once halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ireq_q <= '0;
      ihit_q <= '0;
      dreq_q <= '0;
      dhit_q <= '0;
    end else if (!halted_q) begin
      if (c_icache_req_i) ireq_q <= ireq_q + CNT_W'(1);
      if (c_icache_hit_i) ihit_q <= ihit_q + CNT_W'(1);
      if (c_dcache_req_i) dreq_q <= dreq_q + CNT_W'(1);
      if (c_dcache_hit_i) dhit_q <= dhit_q + CNT_W'(1);
    end
  end

  assign icache_req_count_o = ireq_q;
  assign icache_hit_count_o = ihit_q;
  assign dcache_req_count_o = dreq_q;
  assign dcache_hit_count_o = dhit_q;
`else
  logic unused_cache;
  assign unused_cache = c_icache_req_i ^ c_icache_hit_i ^ c_dcache_req_i ^ c_dcache_hit_i;
`endif

endmodule

// File: tb/tb_commit_trace_unit.sv
// Self-checking bench for commit_trace_unit: queue-based reference model plus directed
// literal checks and a randomized phase. Honours TRACE_CACHE_STATS_EN like the design.
module tb_commit_trace_unit;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic c_reg_wr, c_mem_rd, c_mem_wr, c_halt;
  logic [2:0] c_reg_sel;
  logic [15:0] c_reg_data, c_mem_addr, c_mem_wdata, c_mem_rdata;
  logic c_icache_req, c_icache_hit, c_dcache_req, c_dcache_hit;
  logic trc_ready;
  logic trc_valid;
  logic [37:0] trc_data;
  logic halted, overflow;
  logic [15:0] drop_count;
  logic [CNT_W-1:0] cycle_count, inst_count;
`ifdef TRACE_CACHE_STATS_EN
  logic [CNT_W-1:0] icache_req_count, icache_hit_count, dcache_req_count, dcache_hit_count;
`endif

  commit_trace_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .c_reg_wr_i        (c_reg_wr),
    .c_reg_sel_i       (c_reg_sel),
    .c_reg_data_i      (c_reg_data),
    .c_mem_rd_i        (c_mem_rd),
    .c_mem_wr_i        (c_mem_wr),
    .c_mem_addr_i      (c_mem_addr),
    .c_mem_wdata_i     (c_mem_wdata),
    .c_mem_rdata_i     (c_mem_rdata),
    .c_halt_i          (c_halt),
    .c_icache_req_i    (c_icache_req),
    .c_icache_hit_i    (c_icache_hit),
    .c_dcache_req_i    (c_dcache_req),
    .c_dcache_hit_i    (c_dcache_hit),
    .trc_valid_o       (trc_valid),
    .trc_ready_i       (trc_ready),
    .trc_data_o        (trc_data),
    .halted_o          (halted),
    .overflow_o        (overflow),
    .drop_count_o      (drop_count),
`ifdef TRACE_CACHE_STATS_EN
    .icache_req_count_o(icache_req_count),
    .icache_hit_count_o(icache_hit_count),
    .dcache_req_count_o(dcache_req_count),
    .dcache_hit_count_o(dcache_hit_count),
`endif
    .cycle_count_o     (cycle_count),
    .inst_count_o      (inst_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of records and integer counters.
  logic [37:0] mq[$];
  bit m_halted, m_overflow;
  int unsigned m_drop;
  logic [CNT_W-1:0] m_cycle, m_inst, m_ireq, m_ihit, m_dreq, m_dhit;

  function automatic void model_reset();
    mq.delete();
    m_halted = 0; m_overflow = 0; m_drop = 0;
    m_cycle = '0; m_inst = '0;
    m_ireq = '0; m_ihit = '0; m_dreq = '0; m_dhit = '0;
  endfunction

  function automatic logic [37:0] model_rec();
    if (c_mem_wr) return {c_halt, 2'b10, 3'd0, c_mem_addr, c_mem_wdata};
    if (c_mem_rd) return {c_halt, 2'b01, (c_reg_wr ? c_reg_sel : 3'd0), c_mem_addr, c_mem_rdata};
    if (c_reg_wr) return {c_halt, 2'b00, c_reg_sel, 16'h0000, c_reg_data};
    return {c_halt, 2'b11, 3'd0, 32'h0};
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      bit act;
      act = (c_reg_wr | c_mem_rd | c_mem_wr | c_halt) && !m_halted;
      if (mq.size() > 0 && trc_ready) void'(mq.pop_front());
      if (act) begin
        if (mq.size() < DEPTH) mq.push_back(model_rec());
        else begin
          m_overflow = 1;
          if (m_drop < 32'hFFFF) m_drop++;
        end
      end
      if (!m_halted) begin
        m_cycle = m_cycle + 1;
        m_ireq = m_ireq + CNT_W'(c_icache_req);
        m_ihit = m_ihit + CNT_W'(c_icache_hit);
        m_dreq = m_dreq + CNT_W'(c_dcache_req);
        m_dhit = m_dhit + CNT_W'(c_dcache_hit);
      end
      if (act && (c_halt | c_reg_wr | c_mem_wr)) m_inst = m_inst + 1;
      if (act && c_halt) m_halted = 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("valid", 64'(trc_valid), 64'(mq.size() != 0));
      check("data", 64'(trc_data), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
      check("halted", 64'(halted), 64'(m_halted));
      check("overflow", 64'(overflow), 64'(m_overflow));
      check("drop_count", 64'(drop_count), 64'(m_drop));
      check("cycle_count", 64'(cycle_count), 64'(m_cycle));
      check("inst_count", 64'(inst_count), 64'(m_inst));
`ifdef TRACE_CACHE_STATS_EN
      check("icache_req", 64'(icache_req_count), 64'(m_ireq));
      check("icache_hit", 64'(icache_hit_count), 64'(m_ihit));
      check("dcache_req", 64'(dcache_req_count), 64'(m_dreq));
      check("dcache_hit", 64'(dcache_hit_count), 64'(m_dhit));
`endif
    end
  end

  task automatic clr_inputs();
    c_reg_wr = 0; c_mem_rd = 0; c_mem_wr = 0; c_halt = 0;
    c_reg_sel = 0; c_reg_data = 0; c_mem_addr = 0; c_mem_wdata = 0; c_mem_rdata = 0;
    c_icache_req = 0; c_icache_hit = 0; c_dcache_req = 0; c_dcache_hit = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset between edges; returns at a negedge with reset released.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 64'(trc_valid), 64'd0);
    check("rst_data", 64'(trc_data), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_cycle", 64'(cycle_count), 64'd0);
    check("rst_inst", 64'(inst_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] exp_drain [DEPTH];
  logic [CNT_W-1:0] frozen_cycle;

  initial begin
    clr_inputs();
    trc_ready = 0;
    model_reset();
    cmp_en = 1;
    do_reset();

    // Single register-write record.
    trc_ready = 1;
    c_reg_wr = 1; c_reg_sel = 3'd3; c_reg_data = 16'h1234;
    step();
    clr_inputs();
    check("reg_rec", 64'(trc_data), 64'(38'h0_0_3_0000_1234));
    check("reg_inst", 64'(inst_count), 64'd1);
    check("reg_cycle", 64'(cycle_count), 64'd1);

    // Load with register write.
    c_mem_rd = 1; c_reg_wr = 1; c_reg_sel = 3'd5; c_mem_addr = 16'h0040; c_mem_rdata = 16'hBEEF;
    step();
    clr_inputs();
    check("load_rec", 64'(trc_data), 64'({1'b0, 2'b01, 3'd5, 16'h0040, 16'hBEEF}));
    check("load_inst", 64'(inst_count), 64'd2);
    step();

    // Overflow: DEPTH+3 commits with consumer stalled.
    trc_ready = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      c_reg_wr = 1; c_reg_sel = 3'(i); c_reg_data = 16'h0100 + 16'(i);
      step();
    end
    clr_inputs();
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drop", 64'(drop_count), 64'd3);
    check("ovf_head", 64'(trc_data[15:0]), 64'h0100);

    // Full FIFO with simultaneous pop: push accepted, no drop.
    c_reg_wr = 1; c_reg_sel = 3'd7; c_reg_data = 16'h0200;
    trc_ready = 1;
    step();
    clr_inputs();
    check("fullpop_drop", 64'(drop_count), 64'd3);
    check("fullpop_head", 64'(trc_data[15:0]), 64'h0101);

    // Drain: remaining records in order.
    for (int i = 0; i < DEPTH - 1; i++) exp_drain[i] = 16'h0101 + 16'(i);
    exp_drain[DEPTH-1] = 16'h0200;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 64'(trc_data[15:0]), 64'(exp_drain[i]));
      step();
    end
    check("drain_empty", 64'(trc_valid), 64'd0);

    // Randomized traffic, with an asynchronous reset partway through.
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) begin
        do_reset();
      end
      c_reg_wr     = ($urandom_range(0, 1) == 1);
      c_mem_rd     = ($urandom_range(0, 3) == 0);
      c_mem_wr     = ($urandom_range(0, 3) == 0);
      c_reg_sel    = 3'($urandom);
      c_reg_data   = 16'($urandom);
      c_mem_addr   = 16'($urandom);
      c_mem_wdata  = 16'($urandom);
      c_mem_rdata  = 16'($urandom);
      c_icache_req = 1'($urandom);
      c_icache_hit = 1'($urandom);
      c_dcache_req = 1'($urandom);
      c_dcache_hit = 1'($urandom);
      // Alternate stretches of mostly-stalled and mostly-ready consumer.
      trc_ready = ((n / 100) % 2 == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    clr_inputs();

    // Cache events, then store-with-halt.
    do_reset();
    trc_ready = 0;
    for (int i = 0; i < 4; i++) begin
      c_dcache_req = 1; c_dcache_hit = (i != 2);
      step();
    end
    clr_inputs();
    c_mem_wr = 1; c_halt = 1; c_mem_addr = 16'h0010; c_mem_wdata = 16'h00FF;
    step();
    clr_inputs();
    check("halt_rec", 64'(trc_data), 64'({1'b1, 2'b10, 3'd0, 16'h0010, 16'h00FF}));
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_inst", 64'(inst_count), 64'd1);
    check("halt_cycle", 64'(cycle_count), 64'd5);
`ifdef TRACE_CACHE_STATS_EN
    check("dcache_req4", 64'(dcache_req_count), 64'd4);
    check("dcache_hit3", 64'(dcache_hit_count), 64'd3);
`endif
    frozen_cycle = cycle_count;
    for (int i = 0; i < 5; i++) begin
      c_reg_wr = 1; c_mem_wr = (i == 2); c_reg_data = 16'(i); c_dcache_req = 1;
      step();
    end
    clr_inputs();
    check("post_halt_cycle", 64'(cycle_count), 64'(frozen_cycle));
    check("post_halt_inst", 64'(inst_count), 64'd1);
    check("post_halt_drop", 64'(drop_count), 64'd0);
    trc_ready = 1;
    step();
    check("post_halt_empty", 64'(trc_valid), 64'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
